// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Drives the Mini TPU 16-bit instruction bus. It collects 32 operand bytes
// (Memory A row-major, then Memory B row-major) and turns each byte into a
// LOAD word. It then issues START, lets the array run for RUN_CYCLES cycles,
// issues STOP, and walks the 16 result cells with STORE words. Each sampled
// result is returned over a valid/ready stream.
//
// Instruction word layout:
//   [15:14] opcode  (START=00, STOP=01, LOAD=10, STORE=11)
//   [13]    memory select (0=A, 1=B)
//   [12]    always 0
//   [11:10] row, [9:8] col
//   [7:0]   immediate (operand byte for LOAD)
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   in_valid      operand byte valid
//   in_data       operand byte
//   in_ready      sequencer accepts an operand byte (IDLE and LOAD only)
//   instruction   registered instruction word to the control unit
//   array_result  array output for the row/col of the current STORE word
//   out_valid     result word valid
//   out_data      result word
//   out_last      marks the 16th result (row 3, col 3)
//   out_ready     downstream accepts the result
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse after the last result is accepted
//
// Every output comes straight from a register. The state register leads the
// instruction register by one cycle: the word a state is responsible for is
// loaded into the instruction register on the edge that leaves that state.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int ACC_WIDTH      = 16,
  parameter int RUN_CYCLES     = 10,  // 1..255
  parameter int RESULT_LATENCY = 1    // 0..3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic [15:0]          instruction,
  input  logic [ACC_WIDTH-1:0] array_result,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  // STORE r0 c0 is harmless to the control unit, so it doubles as the filler
  // word. 16'h0000 would be START and must never be used as filler.
  localparam logic [15:0] IDLE_WORD  = 16'hC000;
  localparam logic [15:0] START_WORD = 16'h0000;
  localparam logic [15:0] STOP_WORD  = 16'h4000;

  // A STORE word is held RESULT_LATENCY+1 cycles; the hold counter reaches
  // this value on the edge that ends the last of those cycles.
  localparam logic [2:0] STORE_HOLD = 3'(RESULT_LATENCY + 1);
  localparam logic [7:0] RUN_LAST   = 8'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_STOP,
    S_STORE,
    S_OUT
  } state_t;

  state_t                 state_reg,     state_next;
  logic [4:0]             load_idx_reg,  load_idx_next;
  logic [3:0]             res_idx_reg,   res_idx_next;
  logic [7:0]             run_cnt_reg,   run_cnt_next;
  logic [2:0]             hold_cnt_reg,  hold_cnt_next;
  logic [15:0]            instr_reg,     instr_next;
  logic                   in_ready_reg,  in_ready_next;
  logic                   out_valid_reg, out_valid_next;
  logic [ACC_WIDTH-1:0]   out_data_reg,  out_data_next;
  logic                   out_last_reg,  out_last_next;
  logic                   busy_reg,      busy_next;
  logic                   done_reg,      done_next;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & out_ready;

  // Operand index k maps to memory k[4], row k[3:2], col k[1:0].
  function automatic logic [15:0] load_word(input logic [4:0] k,
                                            input logic [7:0] data);
    return {2'b10, k[4], 1'b0, k[3:2], k[1:0], data};
  endfunction

  function automatic logic [15:0] store_word(input logic [3:0] idx);
    return {2'b11, 2'b00, idx[3:2], idx[1:0], 8'h00};
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    load_idx_next  = load_idx_reg;
    res_idx_next   = res_idx_reg;
    run_cnt_next   = run_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    instr_next     = IDLE_WORD;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    done_next      = 1'b0;

    case (state_reg)
      // IDLE and LOAD behave identically on an accepted byte: the byte at
      // load_idx becomes a LOAD word on the next cycle. The first byte is
      // taken in IDLE, which moves the sequencer into LOAD.
      S_IDLE, S_LOAD: begin
        if (in_fire) begin
          instr_next = load_word(load_idx_reg, in_data);
          if (load_idx_reg == 5'd31) begin
            // Index stays at 31 so it never wraps mid-operation.
            state_next = S_START;
          end else begin
            load_idx_next = load_idx_reg + 5'd1;
            state_next    = S_LOAD;
          end
        end
      end

      S_START: begin
        instr_next   = START_WORD;
        run_cnt_next = 8'd0;
        state_next   = S_RUN;
      end

      // Filler words for exactly RUN_CYCLES cycles after START.
      S_RUN: begin
        if (run_cnt_reg == RUN_LAST) begin
          state_next = S_STOP;
        end else begin
          run_cnt_next = run_cnt_reg + 8'd1;
        end
      end

      S_STOP: begin
        instr_next    = STOP_WORD;
        hold_cnt_next = 3'd0;
        state_next    = S_STORE;
      end

      // The STORE word is presented on the first edge here (hold count 0->1)
      // and held; array_result is sampled on the edge that ends the last
      // hold cycle, when it is valid for the presented row/col.
      S_STORE: begin
        instr_next = store_word(res_idx_reg);
        if (hold_cnt_reg == STORE_HOLD) begin
          out_data_next  = array_result;
          out_valid_next = 1'b1;
          out_last_next  = (res_idx_reg == 4'd15);
          state_next     = S_OUT;
        end else begin
          hold_cnt_next = hold_cnt_reg + 3'd1;
        end
      end

      // Result offered downstream; the STORE word stays on the bus.
      S_OUT: begin
        instr_next = instr_reg;
        if (out_fire) begin
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
          if (res_idx_reg == 4'd15) begin
            instr_next    = IDLE_WORD;
            done_next     = 1'b1;
            res_idx_next  = 4'd0;
            load_idx_next = 5'd0;
            state_next    = S_IDLE;
          end else begin
            // Present the next STORE word on this same edge so a result
            // completes every RESULT_LATENCY+2 cycles under full throughput.
            res_idx_next  = res_idx_reg + 4'd1;
            instr_next    = store_word(res_idx_reg + 4'd1);
            hold_cnt_next = 3'd1;
            state_next    = S_STORE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Registered flags follow the state being entered, so in_ready drops on
    // the same edge that accepts byte 31 and no 33rd byte can slip in.
    in_ready_next = (state_next == S_IDLE) || (state_next == S_LOAD);
    busy_next     = (state_next != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      load_idx_reg  <= 5'd0;
      res_idx_reg   <= 4'd0;
      run_cnt_reg   <= 8'd0;
      hold_cnt_reg  <= 3'd0;
      instr_reg     <= IDLE_WORD;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      load_idx_reg  <= load_idx_next;
      res_idx_reg   <= res_idx_next;
      run_cnt_reg   <= run_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      instr_reg     <= instr_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign instruction = instr_reg;
  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_last    = out_last_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Randomized bench for instr_sequencer. The reference model works on the whole
// transaction: the expected LOAD word list is derived from byte index
// arithmetic, the instruction stream is logged each cycle and then scanned for
// the START / run window / STOP / STORE pattern, and results are matched
// against an ordered list of expected cell values.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int ACC_WIDTH      = 16;
  localparam int RUN_CYCLES     = 10;
  localparam int RESULT_LATENCY = 1;
  localparam logic [15:0] IDLE_WORD = 16'hC000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [7:0]           in_data = 8'h00;
  logic                 in_ready;
  logic [15:0]          instruction;
  logic [ACC_WIDTH-1:0] array_result;
  logic                 out_valid;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_ready = 1'b0;
  logic                 busy;
  logic                 done;

  instr_sequencer #(
    .ACC_WIDTH      (ACC_WIDTH),
    .RUN_CYCLES     (RUN_CYCLES),
    .RESULT_LATENCY (RESULT_LATENCY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .instruction  (instruction),
    .array_result (array_result),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Array model: one cycle after a STORE word, present {row, col, 4'h0}.
  logic [15:0] instr_d;
  always @(posedge clk) instr_d <= instruction;
  assign array_result = {8'h00, instr_d[11:8], 4'h0};

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  byte_mem [32];
  logic [15:0] log_q[$];
  int          acc_q[$];
  bit          log_en     = 1'b0;
  int          res_cnt    = 0;
  bit          txn_done   = 1'b0;
  bit          done_exp   = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic [15:0] prev_instr = '0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stall on result 3
  int          stall_left = 0;
  int          mon_cyc;

  // Expected LOAD word for operand index idx, from memory/row/col arithmetic.
  function automatic logic [15:0] exp_load(input int idx);
    int mem, row, col;
    mem = idx / 16;
    row = (idx % 16) / 4;
    col = idx % 4;
    return 16'(32'h8000 + mem * 32'h2000 + row * 1024 + col * 256
               + int'(byte_mem[idx]));
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: logs the bus, checks results, holds and the done pulse.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (log_en) begin
      mon_cyc = log_q.size();
      log_q.push_back(instruction);
      if (done || done_exp) check_eq("done_pulse", done, done_exp);
      done_exp = 1'b0;
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
        check_eq("hold_instr", instruction, prev_instr);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_instr = instruction;
      if (out_valid && out_ready) begin
        check_eq("res_data", out_data, res_cnt * 16);
        check_eq("res_last", out_last, (res_cnt == 15) ? 1 : 0);
        acc_q.push_back(mon_cyc);
        if (res_cnt == 15) begin
          done_exp = 1'b1;
          txn_done = 1'b1;
          res_cnt  = 0;
        end else begin
          res_cnt++;
        end
      end
    end
  end

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && res_cnt == 3 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks (entered and left at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic fill_bytes(input bit counting);
    for (int i = 0; i < 32; i++)
      byte_mem[i] = counting ? 8'(i + 1) : 8'($urandom_range(0, 255));
  endtask

  task automatic drive_load(input bit gaps);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    while (idx < 32 && cyc < 1000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = byte_mem[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        check_eq("load_word", instruction, exp_load(idx));
        idx++;
      end else begin
        check_eq("gap_word", instruction, IDLE_WORD);
      end
    end
    if (idx < 32) check_eq("load_timeout", idx, 32);
    check_eq("in_ready_after_load", in_ready, 0);
    check_eq("busy_after_load", busy, 1);
    // Keep offering a byte: a 33rd byte must not be taken.
    in_data = 8'hEE;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input bit counting, input bit gaps, input int mode);
    int n_start = 0, n_stop = 0, n_load = 0, p0 = -1, p_stop = -1;
    int bad = 0, nseq = 0, wait_cyc = 0;
    fill_bytes(counting);
    log_q.delete();
    acc_q.delete();
    res_cnt    = 0;
    txn_done   = 1'b0;
    done_exp   = 1'b0;
    prev_stall = 1'b0;
    ready_mode = mode;
    stall_left = 5;
    log_en     = 1'b1;
    drive_load(gaps);
    while (!txn_done && wait_cyc < 3000) begin
      @(posedge clk);
      wait_cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    log_en = 1'b0;
    check_eq("txn_complete", txn_done, 1);
    check_eq("result_count", acc_q.size(), 16);
    check_eq("idle_instr", instruction, IDLE_WORD);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_in_ready", in_ready, 1);

    foreach (log_q[i]) begin
      if (log_q[i] == 16'h0000) begin
        n_start++;
        if (p0 < 0) p0 = i;
      end
      if (log_q[i] == 16'h4000) begin
        n_stop++;
        if (p_stop < 0) p_stop = i;
      end
      if (log_q[i][15:14] == 2'b10) n_load++;
    end
    check_eq("start_count", n_start, 1);
    check_eq("stop_count", n_stop, 1);
    check_eq("load_count", n_load, 32);
    if (p0 > 0 && p_stop > p0) begin
      check_eq("start_after_last_load", log_q[p0 - 1], exp_load(31));
      check_eq("run_window", p_stop - p0 - 1, RUN_CYCLES);
      for (int i = p0 + 1; i < p_stop; i++)
        if (log_q[i] != IDLE_WORD) bad++;
      check_eq("run_idle_words", bad, 0);
      // Collapse repeated words: the STORE addresses must walk r0c0..r3c3.
      for (int i = p_stop + 1; i < log_q.size() && nseq < 16; i++) begin
        if (i == p_stop + 1 || log_q[i] != log_q[i - 1]) begin
          check_eq("store_word", log_q[i], 32'hC000 + nseq * 256);
          nseq++;
        end
      end
      check_eq("store_words_seen", nseq, 16);
      if (mode == 0 && acc_q.size() == 16) begin
        check_eq("first_result_latency", acc_q[0] - p_stop, RESULT_LATENCY + 2);
        bad = 0;
        for (int i = 1; i < 16; i++)
          if (acc_q[i] - acc_q[i - 1] != RESULT_LATENCY + 2) bad++;
        check_eq("result_spacing", bad, 0);
      end
    end
    $display("txn mode=%0d gaps=%0d: %0d cycles logged, %0d results", mode, gaps,
             log_q.size(), acc_q.size());
  endtask

  task automatic reset_during_run();
    int bad = 0;
    fill_bytes(1'b0);
    ready_mode = 0;
    drive_load(1'b0);  // returns a few cycles into the run window
    check_eq("in_run_before_reset", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_instr", instruction, IDLE_WORD);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_done", done, 0);
    @(posedge clk);
    #1;
    check_eq("rst_in_ready_next", in_ready, 1);
    repeat (15) begin
      @(posedge clk);
      #1;
      if (instruction != IDLE_WORD || busy) bad++;
    end
    check_eq("no_stop_after_reset", bad, 0);
    $display("reset during run: %0d non-idle cycles after reset", bad);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_instr", instruction, IDLE_WORD);
    check_eq("reset_in_ready", in_ready, 0);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_last", out_last, 0);
    check_eq("reset_out_data", out_data, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("in_ready_after_reset", in_ready, 1);

    run_txn(1'b1, 1'b0, 0);  // bytes 0x01..0x20, no gaps, full throughput
    run_txn(1'b0, 1'b1, 2);  // input gaps, 5-cycle stall on result 3
    run_txn(1'b0, 1'b1, 1);  // input gaps, random backpressure
    reset_during_run();
    run_txn(1'b0, 1'b0, 0);  // fresh load after reset
    run_txn(1'b0, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Initiator for the Mini TPU 16-bit instruction bus; it drives `instruction` into the control unit.
- Accepts a byte stream of operands and emits LOAD words for all of Memory A, then all of Memory B.
- Then emits START, waits a fixed run window, emits STOP, and issues STORE for each of the 16 result cells.
- Streams the captured array results out over a valid/ready interface.

Parameters:
- ACC_WIDTH, 16, width of array result sampled during STORE.
- RUN_CYCLES, 10, cycles between START and STOP (range 1..255).
- RESULT_LATENCY, 1, cycles from STORE word presented to array_result valid (range 0..3).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand byte valid
- in_data  input  8  operand byte; A row-major (16 bytes), then B row-major (16 bytes)
- in_ready  output  1  sequencer accepts operand byte
- instruction  output  16  instruction word to control unit, registered
- array_result  input  ACC_WIDTH  array output selected by current STORE row/col
- out_valid  output  1  result word valid
- out_data  output  ACC_WIDTH  result word
- out_last  output  1  marks 16th result (row 3, col 3)
- out_ready  input  1  downstream accepts result
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after last result accepted

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Encoding:
  - [15:14] opcode: START=00, STOP=01, LOAD=10, STORE=11.
  - [13] memory select: 0=A, 1=B.
  - [12] is 0.
  - [11:10] row, [9:8] col, [7:0] immediate.
- Idle word is 16'hC000 (STORE r0 c0, harmless). It is emitted in every cycle not listed below. 16'h0000 is START, so it must never be emitted as filler.
- Reset:
  - state=IDLE, instruction=16'hC000.
  - in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - load_idx=0, res_idx=0, all counters 0.
- All outputs are registered.
- in_ready=1 in IDLE and LOAD only, from the first cycle after rst deasserts.

States:
- IDLE:
  - Byte accepted (in_valid&in_ready) → load_idx 0 consumed, go LOAD.
- LOAD:
  - Each accepted byte k (k=load_idx) → next cycle instruction={2'b10, k[4], 1'b0, k[3:2], k[1:0], in_data}.
  - Cycles without a byte → idle word.
  - After byte k=31 is accepted → START. in_ready drops in the same edge, so a 33rd byte is never accepted.
- START: instruction=16'h0000 for exactly 1 cycle → RUN.
- RUN: idle word for RUN_CYCLES cycles → STOP.
- STOP: instruction=16'h4000 for 1 cycle → STORE.
- STORE:
  - instruction={2'b11, 2'b00, res_idx[3:2], res_idx[1:0], 8'h00}, held RESULT_LATENCY+1 cycles.
  - array_result is captured into out_data on the final cycle → OUT.
- OUT:
  - out_valid=1, out_last=(res_idx==15). The STORE word remains on instruction.
  - out_data/out_last stable until out_ready.
  - On acceptance: res_idx<15 → res_idx+1, STORE. res_idx==15 → IDLE, done=1 for 1 cycle, instruction=idle word.
- Timing example: with START at cycle T and RUN_CYCLES=10, RUN covers T+1..T+10, STOP is at T+11, and the first STORE word is at T+12.
- load_idx and res_idx are 5-/4-bit. They are cleared on returning to IDLE and never wrap mid-operation.
- out_ready held high gives one result per RESULT_LATENCY+2 cycles.
- in_valid is ignored outside IDLE/LOAD. out_ready is ignored outside OUT.
- rst mid-operation:
  - Next cycle matches the reset state exactly; no STOP is emitted.
  - System reset must also reset the control unit.
- in_valid low for any number of cycles in LOAD stalls without state change.

Test Plan:
- Full load:
  - Stimulus: bytes 0x01..0x20, in_valid held high.
  - First LOAD word is 16'h8001 (A r0 c0), in the cycle after the first acceptance.
  - Byte 16 (0x10) gives 16'h8F10 (A r3 c3); byte 17 (0x11) gives 16'hA011 (B r0 c0); byte 32 gives 16'hAF20.
  - in_ready=0 after 32 accepts.
- Sequencing:
  - After the last LOAD, 16'h0000 appears exactly once, followed by 10 cycles of 16'hC000 and then 16'h4000 once.
  - The first STORE word is 16'hC000 (r0 c0), then 16'hC100 (r0 c1).
- Result capture:
  - Bench model drives array_result={8'h0, row, col, 4'h0} one cycle after each STORE.
  - out_data sequence is 0x0000, 0x0010 … 0x00F0.
  - out_last is set only on 0x00F0; a done pulse follows acceptance.
- Backpressure:
  - out_ready low for 5 cycles during result 3 → out_valid/out_data held; STORE word r0 c3 held.
  - No result is skipped or duplicated.
- Input gaps: in_valid toggled 1/0 → idle words interleave, LOAD addresses stay contiguous, still 32 LOADs.
- Reset during RUN: rst pulsed one cycle → instruction=16'hC000, busy=0, in_ready=1; a fresh 32-byte load then starts again at 16'h80xx.
